// File: rtl/seven_bit_deserializer_pkg.sv
// Shared definitions for the 7-to-1 serial link.
// Holds the state encoding and the word/index width defaults. The transmitter
// uses the same widths, so both ends of the link agree on the word size.
package seven_bit_deserializer_pkg;

  localparam int DESER_WIDTH = 7;
  localparam int DESER_IDX_W = 3;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/seven_bit_deserializer_bit_index_counter.sv
// Bit position counter for the deserializer.
// Ports:
//   clock, resetn : system clock, async active-low reset
//   clr           : synchronous clear to 0
//   load1         : synchronous load of 1 (highest priority)
//   en            : increment by one
//   count         : current bit position
//   term          : count is at the last bit position (WIDTH-1)
module bit_index_counter
  import seven_bit_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  parameter int IDX_W = DESER_IDX_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             term
);

  assign term = (count == IDX_W'(WIDTH - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load1) begin
      count <= IDX_W'(1);
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      // Wrap at the last position so index values >= WIDTH are never produced.
      count <= term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_bit_deserializer.sv
// Receive side of the 7-to-1 serial link: rebuilds a WIDTH-bit word from
// strobed serial bits, bit 0 first.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for start; strobes are ignored
// S_COLLECT | frame in progress; each strobe writes staging[bit_index]
//
// Ports:
//   clock, resetn : system clock, async active-low reset
//   start         : frame start / abort, clears staging and the index
//   bit_in        : serial data, sampled when bit_valid=1
//   bit_valid     : one-cycle strobe qualifying bit_in
//   word_out      : last completed word (bit k = k-th bit received)
//   word_valid    : one-cycle pulse when word_out was just updated
//   busy          : high while collecting a frame
//   bit_index     : next bit position to be written
module seven_bit_deserializer
  import seven_bit_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  parameter int IDX_W = DESER_IDX_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             busy,
  output logic [IDX_W-1:0] bit_index
);

  deser_state_t     state;
  logic [WIDTH-1:0] staging;
  logic             idx_term;
  logic             idx_clr;
  logic             idx_load1;
  logic             idx_en;
  logic             accept;

  // A strobe in COLLECT counts only when start is not also asserted;
  // start always wins and restarts the frame.
  assign accept    = (state == S_COLLECT) && bit_valid && !start;
  assign idx_load1 = start && bit_valid;
  assign idx_clr   = (start && !bit_valid) || (accept && idx_term);
  assign idx_en    = accept;

  bit_index_counter #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_idx (
    .clock (clock),
    .resetn(resetn),
    .clr   (idx_clr),
    .load1 (idx_load1),
    .en    (idx_en),
    .count (bit_index),
    .term  (idx_term)
  );

  assign busy = (state == S_COLLECT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      staging    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (start) begin
        staging    <= '0;
        staging[0] <= bit_valid & bit_in;
        state      <= S_COLLECT;
      end else if (accept) begin
        if (idx_term) begin
          // Last bit goes straight to the output; staging never holds it.
          word_out   <= {bit_in, staging[WIDTH-2:0]};
          word_valid <= 1'b1;
          state      <= S_IDLE;
        end else begin
          for (int k = 0; k < WIDTH - 1; k++) begin
            if (bit_index == IDX_W'(k)) staging[k] <= bit_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_bit_deserializer.sv
module tb_seven_bit_deserializer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [6:0] word_out;
  logic       word_valid;
  logic       busy;
  logic [2:0] bit_index;

  int n_checks = 0;
  int n_fail = 0;

  seven_bit_deserializer dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .busy      (busy),
    .bit_index (bit_index)
  );

  always #5 clock = ~clock;

  // Reference model: a frame is just the list of bits received so far.
  logic [6:0] m_word = '0;
  bit         m_valid = 1'b0;
  bit         m_coll = 1'b0;
  bit         m_bits[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_word = '0;
    m_valid = 1'b0;
    m_coll = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_edge(input bit s, input bit v, input bit b);
    m_valid = 1'b0;
    if (s) begin
      m_bits.delete();
      if (v) m_bits.push_back(b);
      m_coll = 1'b1;
    end else if (m_coll && v) begin
      m_bits.push_back(b);
      if (m_bits.size() == 7) begin
        m_word = '0;
        foreach (m_bits[k]) if (m_bits[k]) m_word = m_word + 7'(1 << k);
        m_valid = 1'b1;
        m_coll = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  task automatic chk_model();
    chk("model word_out", int'(word_out), int'(m_word));
    chk("model word_valid", int'(word_valid), int'(m_valid));
    chk("model busy", int'(busy), int'(m_coll));
    chk("model bit_index", int'(bit_index), m_bits.size());
  endtask

  task automatic step(input bit s, input bit v, input bit b);
    @(negedge clock);
    start = s;
    bit_valid = v;
    bit_in = b;
    @(posedge clock);
    model_edge(s, v, b);
    #1;
    chk_model();
  endtask

  task automatic chk_zero(input string name);
    chk({name, " word_out"}, int'(word_out), 0);
    chk({name, " word_valid"}, int'(word_valid), 0);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " bit_index"}, int'(bit_index), 0);
  endtask

  typedef struct {
    bit         s;
    bit         v;
    bit         b;
    logic [6:0] e_word;
    bit         e_wv;
    bit         e_busy;
    int         e_idx;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int vcount;
    logic [6:0] held;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      start = 1'($urandom);
      bit_valid = 1'($urandom);
      bit_in = 1'($urandom);
      @(posedge clock);
      #1;
      chk_zero("reset hold");
    end
    @(negedge clock);
    start = 0;
    bit_valid = 0;
    resetn = 1'b1;
    model_reset();

    // Basic frame, then start+valid with back-to-back strobes.
    vecs.push_back('{1, 0, 0, 7'b0000000, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 7'b0000000, 0, 1, 1});
    vecs.push_back('{0, 1, 0, 7'b0000000, 0, 1, 2});
    vecs.push_back('{0, 1, 1, 7'b0000000, 0, 1, 3});
    vecs.push_back('{0, 1, 1, 7'b0000000, 0, 1, 4});
    vecs.push_back('{0, 1, 0, 7'b0000000, 0, 1, 5});
    vecs.push_back('{0, 1, 0, 7'b0000000, 0, 1, 6});
    vecs.push_back('{0, 1, 1, 7'b1001101, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 7'b1001101, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 7'b1001101, 0, 1, 1});
    vecs.push_back('{0, 1, 0, 7'b1001101, 0, 1, 2});
    vecs.push_back('{0, 1, 0, 7'b1001101, 0, 1, 3});
    vecs.push_back('{0, 1, 0, 7'b1001101, 0, 1, 4});
    vecs.push_back('{0, 1, 0, 7'b1001101, 0, 1, 5});
    vecs.push_back('{0, 1, 0, 7'b1001101, 0, 1, 6});
    vecs.push_back('{0, 1, 0, 7'b0000001, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 7'b0000001, 0, 0, 0});
    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].v, vecs[i].b);
      chk($sformatf("vec%0d word_out", i), int'(word_out), int'(vecs[i].e_word));
      chk($sformatf("vec%0d word_valid", i), int'(word_valid), int'(vecs[i].e_wv));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d bit_index", i), int'(bit_index), vecs[i].e_idx);
    end

    // Ignored strobes in IDLE.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1);
      chk("idle strobe bit_index", int'(bit_index), 0);
      chk("idle strobe word_out", int'(word_out), 7'b0000001);
    end

    // Abort: 4 ones, restart, 7 zeros -> exactly one word, all zeros.
    vcount = 0;
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1);
      if (word_valid) vcount++;
    end
    step(1, 0, 0);
    if (word_valid) vcount++;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("abort held word_out", int'(word_out), 7'b0000001);
      step(0, 1, 0);
      if (word_valid) vcount++;
    end
    chk("abort word_valid count", vcount, 1);
    chk("abort word_out", int'(word_out), 0);

    // Start coincident with the 7th strobe: start wins, no word.
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    step(1, 1, 1);
    chk("start@7th word_valid", int'(word_valid), 0);
    chk("start@7th bit_index", int'(bit_index), 1);
    chk("start@7th word_out", int'(word_out), 0);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1'(i % 2));
    chk("after start@7th word_valid", int'(word_valid), 1);
    chk("after start@7th word_out", int'(word_out), 7'b0101010);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    end

    // Async reset mid-frame after 3 bits.
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    step(0, 1, 1);
    held = word_out;
    chk("pre-reset word_out nonzero", int'(held != 0), 1);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    @(negedge clock);
    start = 0;
    bit_valid = 0;
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("async reset");
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
